// File: rtl/cpu_alu_sequencer.sv
// Sequences the 6502 combinational ALU: one request in, k ALU cycles, one result out.
// Optional N/Z result flags are built when CPU_ALU_SEQ_FLAGS_EN is defined.
module cpu_alu_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [2:0] req_op,
  input  logic [7:0] req_a,
  input  logic [7:0] req_b,
  input  logic [3:0] req_cnt,
  output logic       alu_add,
  output logic       alu_sub,
  output logic       alu_or,
  output logic       alu_and,
  output logic       alu_eor,
  output logic       alu_inc_a,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  input  logic [7:0] alu_out,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_data,
  output logic       res_n,
  output logic       res_z
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t     state_reg, state_next;
  logic [3:0] cnt_reg, cnt_next;
  logic [7:0] a_reg, a_next;
  logic [7:0] b_reg, b_next;
  logic [7:0] res_data_reg, res_data_next;
  logic [5:0] sel_reg, sel_next;
  logic [5:0] sel_dec;
  logic       last_exec;

  // Select bit gi corresponds to opcode gi+1 (ADD..INC); PASS and 7 decode to none.
  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_sel_dec
      assign sel_dec[gi] = (req_op == 3'(gi + 1));
    end
  endgenerate

  assign last_exec = (state_reg == EXEC) && (cnt_reg == 4'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      cnt_reg      <= 4'd0;
      a_reg        <= 8'd0;
      b_reg        <= 8'd0;
      res_data_reg <= 8'd0;
      sel_reg      <= 6'd0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      a_reg        <= a_next;
      b_reg        <= b_next;
      res_data_reg <= res_data_next;
      sel_reg      <= sel_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    a_next        = a_reg;
    b_next        = b_reg;
    res_data_next = res_data_reg;
    sel_next      = sel_reg;
    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          a_next     = req_a;
          b_next     = req_b;
          cnt_next   = (req_op == 3'd6 && req_cnt != 4'd0) ? req_cnt : 4'd1;
          sel_next   = sel_dec;
          state_next = EXEC;
        end
      end
      EXEC: begin
        // Feed the result back so repeated INC walks alu_a forward.
        a_next   = alu_out;
        cnt_next = cnt_reg - 4'd1;
        if (cnt_reg == 4'd1) begin
          res_data_next = alu_out;
          sel_next      = 6'd0;
          state_next    = DONE;
        end
      end
      DONE: begin
        if (res_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef CPU_ALU_SEQ_FLAGS_EN
  logic res_n_reg, res_z_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_n_reg <= 1'b0;
      res_z_reg <= 1'b0;
    end else if (last_exec) begin
      res_n_reg <= alu_out[7];
      res_z_reg <= (alu_out == 8'd0);
    end
  end

  assign res_n = res_n_reg;
  assign res_z = res_z_reg;
`else
  logic unused_last_exec;
  assign unused_last_exec = last_exec;
  assign res_n = 1'b0;
  assign res_z = 1'b0;
`endif

  // Gated by rst_n so the handshake stays closed while reset is held.
  assign req_ready = (state_reg == IDLE) && rst_n;
  assign res_valid = (state_reg == DONE);
  assign res_data  = res_data_reg;
  assign alu_a     = a_reg;
  assign alu_b     = b_reg;
  assign {alu_inc_a, alu_eor, alu_and, alu_or, alu_sub, alu_add} = sel_reg;

endmodule

// File: tb/tb_cpu_alu_sequencer.sv
// Directed bench for cpu_alu_sequencer with a behavioural ALU attached.
// Flag expectations follow CPU_ALU_SEQ_FLAGS_EN as the RTL is built.
module tb_cpu_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_op;
  logic [7:0] req_a;
  logic [7:0] req_b;
  logic [3:0] req_cnt;
  logic       alu_add, alu_sub, alu_or, alu_and, alu_eor, alu_inc_a;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [7:0] alu_out;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic       res_n;
  logic       res_z;
  logic [5:0] sel;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cpu_alu_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_cnt(req_cnt),
    .alu_add(alu_add), .alu_sub(alu_sub), .alu_or(alu_or),
    .alu_and(alu_and), .alu_eor(alu_eor), .alu_inc_a(alu_inc_a),
    .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_n(res_n), .res_z(res_z)
  );

  assign sel = {alu_inc_a, alu_eor, alu_and, alu_or, alu_sub, alu_add};

  // Behavioural ALU: SUB is B-A, no select means pass A through.
  always_comb begin
    alu_out = alu_a;
    if (alu_add)   alu_out = alu_a + alu_b;
    if (alu_sub)   alu_out = alu_b - alu_a;
    if (alu_or)    alu_out = alu_a | alu_b;
    if (alu_and)   alu_out = alu_a & alu_b;
    if (alu_eor)   alu_out = alu_a ^ alu_b;
    if (alu_inc_a) alu_out = alu_a + 8'd1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic exp_n(input logic [7:0] d);
`ifdef CPU_ALU_SEQ_FLAGS_EN
    return d[7];
`else
    return 1'b0 & d[0];
`endif
  endfunction

  function automatic logic exp_z(input logic [7:0] d);
`ifdef CPU_ALU_SEQ_FLAGS_EN
    return d == 8'd0;
`else
    return 1'b0 & d[0];
`endif
  endfunction

  // Called at a negedge in IDLE; returns at the negedge of the first EXEC cycle.
  task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [3:0] cnt);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_cnt = cnt;
    check("req_ready_idle", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [3:0] cnt, input int k,
                        input logic [5:0] exp_sel, input logic [7:0] exp_d);
    issue(op, a, b, cnt);
    for (int i = 0; i < k; i++) begin
      check({name, "_sel"}, sel, exp_sel);
      check({name, "_alu_a"}, alu_a, (op == 3'd6) ? 8'(a + 8'(i)) : a);
      check({name, "_alu_b"}, alu_b, b);
      check({name, "_busy"}, {res_valid, req_ready}, 2'b00);
      @(negedge clk);
    end
    check({name, "_valid"}, res_valid, 1);
    check({name, "_sel_off"}, sel, 0);
    check({name, "_data"}, res_data, exp_d);
    check({name, "_n"}, res_n, exp_n(exp_d));
    check({name, "_z"}, res_z, exp_z(exp_d));
    $display("txn %s op=%0d a=%02h b=%02h cnt=%0d -> data=%02h n=%0b z=%0b",
             name, op, a, b, cnt, res_data, res_n, res_z);
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    @(negedge clk);
    check({name, "_ret_idle"}, {res_valid, req_ready}, 2'b01);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_op = 3'd0; req_a = 8'd0; req_b = 8'd0;
    req_cnt = 4'd0; res_ready = 1'b0;
    #2;
    check("rst_outs", {sel, alu_a, alu_b, res_data, res_valid, res_n, res_z}, 0);
    check("rst_ready", req_ready, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_ready", req_ready, 1);

    run_op("add",  3'd1, 8'h12, 8'h34, 4'd0, 1, 6'b000001, 8'h46);
    run_op("sub",  3'd2, 8'h05, 8'h05, 4'd0, 1, 6'b000010, 8'h00);
    run_op("or",   3'd3, 8'h0F, 8'h30, 4'd9, 1, 6'b000100, 8'h3F);
    run_op("and",  3'd4, 8'hF0, 8'h3C, 4'd0, 1, 6'b001000, 8'h30);
    run_op("inc3", 3'd6, 8'hFE, 8'h00, 4'd3, 3, 6'b100000, 8'h01);
    run_op("inc0", 3'd6, 8'hFE, 8'h00, 4'd0, 1, 6'b100000, 8'hFF);
    run_op("op7",  3'd7, 8'h80, 8'h11, 4'd0, 1, 6'b000000, 8'h80);
    run_op("pass", 3'd0, 8'h00, 8'h22, 4'd0, 1, 6'b000000, 8'h00);

    // Backpressure with a second request waiting.
    issue(3'd5, 8'hF0, 8'hFF, 4'd0);
    check("bp_eor_sel", sel, 6'b010000);
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd1; req_a = 8'h01; req_b = 8'h02; req_cnt = 4'd0;
    for (int i = 0; i < 5; i++) begin
      check("bp_hold", {res_valid, req_ready, res_data}, {2'b10, 8'h0F});
      check("bp_no_exec", sel, 0);
      @(negedge clk);
    end
    $display("txn bp_eor data=%02h held 5 cycles", res_data);
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    @(negedge clk);
    check("bp_ready_after", {res_valid, req_ready}, 2'b01);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("bp_second_sel", sel, 6'b000001);
    @(negedge clk);
    check("bp_second_data", {res_valid, res_data}, {1'b1, 8'h03});
    $display("txn bp_add data=%02h", res_data);
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    @(negedge clk);

    // Reset in the 3rd EXEC cycle of an 8-step INC.
    issue(3'd6, 8'h10, 8'h00, 4'd8);
    @(negedge clk); @(negedge clk);
    check("mid_alu_a", {sel, alu_a}, {6'b100000, 8'h12});
    rst_n = 1'b0;
    #1;
    check("mid_rst_outs", {sel, alu_a, alu_b, res_data, res_valid, res_n, res_z}, 0);
    check("mid_rst_ready", req_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mid_rel_ready", req_ready, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("mid_no_valid", {res_valid, sel}, 0);
    end
    $display("txn reset_mid_inc ready=%0b valid=%0b", req_ready, res_valid);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
